ibwt_decode: RTL and testbench
==============================

IBWT_DECODE -- requirements
Module: ibwt_decode

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning block length in symbols.
REQ-002 The block SHALL have parameter W, default 8, meaning symbol width in bits.
REQ-003 The block SHALL have parameter IDX_W, default $clog2(N)+1, meaning primary-index width, so out-of-range indices can be expressed.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, as the ports in REQ-005 and REQ-006.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to decode; sampled only in IDLE.
REQ-008 data_in  input  unpacked [0:N-1] of W  BWT last column L; index 0 is the first character.
REQ-009 primary_idx  input  IDX_W  sorted-rotation row index of the original string.
REQ-010 data_out  output  unpacked [0:N-1] of W  reconstructed original string.
REQ-011 busy  output  1  high from capture until DONE exits.
REQ-012 done  output  1  one-cycle pulse; data_out valid.
REQ-013 err  output  1  one-cycle pulse; start rejected because primary_idx >= N.

Function
REQ-014 The FSM SHALL have states IDLE, RANK, WALK and DONE.
REQ-015 In IDLE with start=1 and primary_idx<N, the block SHALL capture data_in into L_reg and primary_idx into p_reg, set busy, clear counter i and enter RANK.
REQ-016 In IDLE with start=1 and primary_idx>=N, the block SHALL pulse err for one cycle, remain in IDLE and leave data_out unchanged.
REQ-017 In RANK, each cycle the block SHALL write LF[i] = count(j: L[j]<L[i]) + count(j<i: L[j]==L[i]), increment i and enter WALK after i=N-1 (N cycles).
REQ-018 LF arithmetic SHALL be unsigned and IDX_W wide; symbol comparisons SHALL be unsigned over W bits.
REQ-019 In WALK, each cycle for k = N-1 down to 0, the block SHALL perform out_reg[k] <= L_reg[p_reg] and p_reg <= LF[p_reg], then enter DONE after k=0 (N cycles).
REQ-020 In DONE, the block SHALL assert done for exactly one cycle, drive data_out from out_reg, deassert busy and return to IDLE.
REQ-021 The done pulse SHALL appear in the cycle after the 2N-th rising edge following the edge that sampled start (cycle 9 for N=4).
REQ-022 data_out SHALL hold its last decoded value until the next DONE or reset; it SHALL NOT change during RANK or WALK.
REQ-023 start asserted while busy SHALL be ignored, and no request SHALL be queued.
REQ-024 A start sampled in the same cycle as DONE SHALL be ignored; the block accepts start only in IDLE.
REQ-025 Repeated symbols, including all-equal input, SHALL decode correctly through the rank term.

Reset
REQ-026 rst=1 SHALL force state IDLE, busy=0, done=0, err=0, data_out all zero, i=0 and p_reg=0, on the clock edge.
REQ-027 Reset during RANK or WALK SHALL abort the decode with no done pulse, and partial results SHALL NOT reach data_out.
REQ-028 rst SHALL take priority over start in the same cycle.
REQ-029 LF storage and L_reg need not be reset.

Structure
REQ-030 Shared package ibwt_pkg SHALL hold defaults N_DEF/W_DEF, the state enum type ibwt_state_t, and the symbol type sym_t (logic [W-1:0]); the bwt merge-sort encoder reuses sym_t.
REQ-031 One sub-module, ibwt_lf_rank, SHALL be combinational: it takes L_reg and i and returns LF[i] via N parallel comparators and popcount.
REQ-032 The FSM, counters, LF register file and output registers SHALL live in ibwt_decode.

Verification
REQ-033 data_in="bcda", primary_idx=1, one-cycle start -> LF={1,2,3,0}; done on the 8th edge after start; data_out="badc"; busy high 9 cycles.
REQ-034 data_in="bbaa", primary_idx=0 -> data_out="abab" (repeated symbols exercise the rank term).
REQ-035 data_in="aaaa", primary_idx=0 -> data_out="aaaa".
REQ-036 primary_idx=4 with start -> err pulse of 1 cycle, busy stays 0, no done, data_out unchanged.
REQ-037 rst asserted 3 cycles into WALK -> next cycle busy=0, data_out=0, no done; a subsequent "bcda"/1 decode -> "badc".
REQ-038 start re-pulsed mid-RANK and in the DONE cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/ibwt_pkg.sv
// Shared types and defaults for the inverse Burrows-Wheeler decoder and its encoder sibling.
package ibwt_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RANK = 2'd1,
        WALK = 2'd2,
        DONE = 2'd3
    } ibwt_state_t;

    typedef logic [W_DEF-1:0] sym_t;

endpackage

// File: rtl/ibwt_lf_rank.sv
// Combinational LF mapping for one row: symbols strictly smaller than L[idx]
// plus equal symbols that appear earlier in L.
module ibwt_lf_rank
    import ibwt_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int IDX_W = $clog2(N) + 1
) (
    input  logic [W-1:0]     l [0:N-1],
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] rank
);

    logic [W-1:0] sel;

    always_comb begin
        sel = '0;
        for (int j = 0; j < N; j++) begin
            if (IDX_W'(j) == idx) sel = l[j];
        end
    end

    // One comparator per position; ties are broken by position so equal symbols keep their order.
    always_comb begin
        rank = '0;
        for (int j = 0; j < N; j++) begin
            if ((l[j] < sel) || ((l[j] == sel) && (IDX_W'(j) < idx))) begin
                rank = rank + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ibwt_decode.sv
// Inverse BWT decoder: ranks the captured last column into an LF table, then
// walks LF from the primary index to rebuild the original string back to front.
//
// state | meaning
// IDLE  | waiting for start; bad primary index pulses err
// RANK  | one LF entry per cycle, i = 0 .. N-1
// WALK  | one output symbol per cycle, k = N-1 down to 0
// DONE  | done pulse, busy drops, back to IDLE
module ibwt_decode
    import ibwt_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int IDX_W = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     data_in [0:N-1],
    input  logic [IDX_W-1:0] primary_idx,
    output logic [W-1:0]     data_out [0:N-1],
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] NUM  = IDX_W'(N);

    ibwt_state_t      state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] p_q, p_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [W-1:0]     l_q    [0:N-1];
    logic [W-1:0]     l_d    [0:N-1];
    logic [IDX_W-1:0] lf_q   [0:N-1];
    logic [IDX_W-1:0] lf_d   [0:N-1];
    logic [W-1:0]     out_q  [0:N-1];
    logic [W-1:0]     out_d  [0:N-1];
    logic [W-1:0]     dout_q [0:N-1];
    logic [W-1:0]     dout_d [0:N-1];

    logic [IDX_W-1:0] rank_val;
    logic [W-1:0]     l_at_p;
    logic [IDX_W-1:0] lf_at_p;

    ibwt_lf_rank #(.N(N), .W(W), .IDX_W(IDX_W)) u_rank (
        .l    (l_q),
        .idx  (i_q),
        .rank (rank_val)
    );

    always_comb begin
        l_at_p  = '0;
        lf_at_p = '0;
        for (int j = 0; j < N; j++) begin
            if (IDX_W'(j) == p_q) begin
                l_at_p  = l_q[j];
                lf_at_p = lf_q[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        p_d     = p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        l_d     = l_q;
        lf_d    = lf_q;
        out_d   = out_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (primary_idx < NUM) begin
                        l_d     = data_in;
                        p_d     = primary_idx;
                        i_d     = '0;
                        busy_d  = 1'b1;
                        state_d = RANK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RANK: begin
                for (int j = 0; j < N; j++) begin
                    if (IDX_W'(j) == i_q) lf_d[j] = rank_val;
                end
                if (i_q == LAST) begin
                    state_d = WALK;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            WALK: begin
                for (int j = 0; j < N; j++) begin
                    if (IDX_W'(j) == i_q) out_d[j] = l_at_p;
                end
                p_d = lf_at_p;
                if (i_q == '0) begin
                    // Publish together with the last symbol so data_out is valid while done is high.
                    dout_d  = out_d;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    i_d = i_q - IDX_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int j = 0; j < N; j++) begin
                out_q[j]  <= '0;
                dout_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            out_q   <= out_d;
            dout_q  <= dout_d;
        end
    end

    // Working storage is always rewritten before use, so it carries no reset.
    always_ff @(posedge clk) begin
        l_q  <= l_d;
        lf_q <= lf_d;
    end

    assign data_out = dout_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ibwt_decode.sv
// Bench for ibwt_decode: fixed vectors, abort/re-start sequences, and random strings
// encoded by a rotation-sorting reference and expected to decode back unchanged.
module tb_ibwt_decode;
    import ibwt_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     data_in  [0:N-1];
    logic [IDX_W-1:0] primary_idx;
    logic [W-1:0]     data_out [0:N-1];
    logic             busy, done, err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ibwt_decode #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .primary_idx (primary_idx),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [31:0]      din;
        logic [IDX_W-1:0] pidx;
        logic [31:0]      exp_out;
        bit               exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] dout_packed();
        logic [31:0] r;
        for (int j = 0; j < N; j++) r[31-8*j -: 8] = data_out[j];
        return r;
    endfunction

    task automatic set_in(input logic [31:0] s, input logic [IDX_W-1:0] p);
        for (int j = 0; j < N; j++) data_in[j] = s[31-8*j -: 8];
        primary_idx = p;
    endtask

    // Forward BWT: sort all rotations; L is the last column, p the row holding s.
    task automatic ref_bwt(input logic [31:0] s, output logic [31:0] l, output logic [IDX_W-1:0] p);
        logic [31:0] rot [0:N-1];
        logic [31:0] tmp;
        logic [31:0] sv;
        bit          found;
        sv = s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                rot[r][31-8*c -: 8] = sv[31-8*((r+c)%N) -: 8];
        for (int a = 0; a < N-1; a++)
            for (int b = 0; b < N-1-a; b++)
                if (rot[b] > rot[b+1]) begin
                    tmp = rot[b]; rot[b] = rot[b+1]; rot[b+1] = tmp;
                end
        found = 0;
        p = '0;
        for (int r = 0; r < N; r++) begin
            l[31-8*r -: 8] = rot[r][7:0];
            if (!found && rot[r] == sv) begin
                p = IDX_W'(r);
                found = 1;
            end
        end
    endtask

    // One-cycle start, then watch a fixed window; cycle c is the half-period after edge c-1.
    task automatic do_req(input logic [31:0] s, input logic [IDX_W-1:0] p,
                          output logic [31:0] dout, output int done_at, output int done_cnt,
                          output int busy_cnt, output int err_cnt);
        @(negedge clk);
        set_in(s, p);
        start = 1'b1;
        done_at = 0; done_cnt = 0; busy_cnt = 0; err_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (busy) busy_cnt++;
            if (err) err_cnt++;
        end
        dout = dout_packed();
    endtask

    initial begin
        logic [31:0]      got, prev, s, l;
        logic [IDX_W-1:0] p;
        int               done_at, done_cnt, busy_cnt, err_cnt;
        bit               bad;

        tbl[0] = '{"bcda", 3'd1, "badc", 1'b0};
        tbl[1] = '{"bbaa", 3'd0, "abab", 1'b0};
        tbl[2] = '{"aaaa", 3'd0, "aaaa", 1'b0};
        tbl[3] = '{"dabc", 3'd0, "abcd", 1'b0};
        tbl[4] = '{"bcda", 3'd4, "abcd", 1'b1};
        tbl[5] = '{"dcba", 3'd7, "abcd", 1'b1};

        rst = 1'b1;
        start = 1'b0;
        set_in(32'h0, 3'd0);
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_data_out", dout_packed(), 32'd0);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            do_req(tbl[t].din, tbl[t].pidx, got, done_at, done_cnt, busy_cnt, err_cnt);
            chk($sformatf("vec%0d_data_out", t), got, tbl[t].exp_out);
            chk($sformatf("vec%0d_done_cnt", t), done_cnt, tbl[t].exp_err ? 0 : 1);
            chk($sformatf("vec%0d_done_cycle", t), done_at, tbl[t].exp_err ? 0 : 9);
            chk($sformatf("vec%0d_busy_cycles", t), busy_cnt, tbl[t].exp_err ? 0 : 9);
            chk($sformatf("vec%0d_err_cycles", t), err_cnt, tbl[t].exp_err ? 1 : 0);
        end

        do_req("bcda", 3'd1, got, done_at, done_cnt, busy_cnt, err_cnt);
        chk("lf0", {29'b0, dut.lf_q[0]}, 32'd1);
        chk("lf1", {29'b0, dut.lf_q[1]}, 32'd2);
        chk("lf2", {29'b0, dut.lf_q[2]}, 32'd3);
        chk("lf3", {29'b0, dut.lf_q[3]}, 32'd0);

        // Reset three cycles into WALK must abort without a done pulse.
        @(negedge clk);
        set_in("dabc", 3'd0);
        start = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (c <= 8) chk($sformatf("abort_data_held_c%0d", c), dout_packed(), "badc");
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_data_out", dout_packed(), 32'd0);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        do_req("bcda", 3'd1, got, done_at, done_cnt, busy_cnt, err_cnt);
        chk("after_abort_data_out", got, "badc");
        chk("after_abort_done_cycle", done_at, 9);

        // Start re-pulsed mid-RANK and in the DONE cycle must be ignored.
        @(negedge clk);
        set_in("bcda", 3'd1);
        start = 1'b1;
        done_at = 0; done_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (busy) busy_cnt++;
            start = (c == 2) || done;
            if (start) set_in("aaaa", 3'd0);
        end
        start = 1'b0;
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_done_cycle", done_at, 9);
        chk("restart_busy_cycles", busy_cnt, 9);
        chk("restart_data_out", dout_packed(), "badc");

        prev = dout_packed();
        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < N; c++) s[31-8*c -: 8] = 8'h61 + 8'($urandom_range(0, 3));
            ref_bwt(s, l, p);
            bad = ($urandom_range(0, 5) == 0);
            if (bad) p = IDX_W'(4 + $urandom_range(0, 3));
            do_req(l, p, got, done_at, done_cnt, busy_cnt, err_cnt);
            chk($sformatf("rand%0d_data_out", it), got, bad ? prev : s);
            chk($sformatf("rand%0d_done_cnt", it), done_cnt, bad ? 0 : 1);
            chk($sformatf("rand%0d_err_cycles", it), err_cnt, bad ? 1 : 0);
            if (!bad) prev = s;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
